// File: rtl/rgb_planar_tx.sv
`default_nettype none
// ============================================================================
// Module   : rgb_planar_tx
// Purpose  : Frame-buffered planar RGB transmitter. Stores one RES_Y x RES_X
//            frame of packed 24-bit pixels, then replays it as three planes
//            (all R bytes, all G bytes, all B bytes) in raster order, one
//            byte per accepted output beat.
// Ports    : clk_i       - clock, rising edge
//            reset       - asynchronous active-high reset
//            pix_in      - pixel {R[23:16], G[15:8], B[7:0]}
//            pix_valid   - pix_in valid
//            pix_ready   - pixel accepted when high (load phase only)
//            rgb_out     - current output byte
//            out_valid   - rgb_out valid
//            out_ready   - downstream accepts rgb_out
//            plane_sel   - plane of rgb_out: 0=R, 1=G, 2=B
//            frame_start - first R byte of the frame is on rgb_out
//            frame_done  - one-cycle pulse after the last B byte transfers
//            frame_cnt   - frames fully transmitted, wraps at 255
// Revision : 1.0 - initial release
// ============================================================================
module rgb_planar_tx #(
    parameter int RES_Y = 32,
    parameter int RES_X = 32
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic [23:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  rgb_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  plane_sel,
    output logic        frame_start,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int c_N      = RES_Y * RES_X;
    localparam int c_IDX_W  = $clog2(c_N) + 1;
    localparam int c_ADDR_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    // State value minus one equals the plane being read in SEND states.
    localparam logic [1:0] c_LOAD   = 2'd0;
    localparam logic [1:0] c_SEND_R = 2'd1;
    localparam logic [1:0] c_SEND_G = 2'd2;
    localparam logic [1:0] c_SEND_B = 2'd3;

    logic [23:0]        r_buf [0:c_N-1];
    logic [1:0]         r_state, w_state_nxt;
    logic [c_IDX_W-1:0] r_wr_idx, r_rd_idx;
    logic               r_rd_done;
    // Read stage (buffer output) and its side-band tags.
    logic [23:0]        r_rd_word;
    logic               r_rd_vld, r_rd_start, r_rd_last;
    logic [1:0]         r_rd_plane;
    logic [7:0]         w_rd_byte;
    // Output stage.
    logic               r_pix_ready, r_out_valid, r_frame_start, r_out_last;
    logic               r_frame_done;
    logic [7:0]         r_rgb_out, r_frame_cnt;
    logic [1:0]         r_plane_sel;

    logic w_accept, w_last_wr, w_out_load, w_rd_adv, w_issue, w_idx_wrap, w_last_beat;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) r_state <= c_LOAD;
        else       r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_LOAD:   if (w_last_wr)              w_state_nxt = c_SEND_R;
            c_SEND_R: if (w_issue && w_idx_wrap)  w_state_nxt = c_SEND_G;
            c_SEND_G: if (w_issue && w_idx_wrap)  w_state_nxt = c_SEND_B;
            // SEND_B lingers after its last read until the final beat drains.
            c_SEND_B: if (w_last_beat)            w_state_nxt = c_LOAD;
            default:                              w_state_nxt = c_LOAD;
        endcase
    end

    // ---------------- control outputs of the FSM ----------------
    always_comb begin
        w_accept    = (r_state == c_LOAD) && r_pix_ready && pix_valid;
        w_last_wr   = w_accept && (r_wr_idx == c_LAST);
        // Output register may take a new byte when empty or being consumed;
        // the read stage may advance when its word moves on (or it is empty).
        w_out_load  = !r_out_valid || out_ready;
        w_rd_adv    = !r_rd_vld || w_out_load;
        w_issue     = (r_state != c_LOAD) && !r_rd_done && w_rd_adv;
        w_idx_wrap  = (r_rd_idx == c_LAST);
        w_last_beat = r_out_valid && out_ready && r_out_last;
    end

    // ---------------- frame buffer ----------------
    always_ff @(posedge clk_i) begin
        if (w_accept) r_buf[r_wr_idx[c_ADDR_W-1:0]] <= pix_in;
        if (w_issue)  r_rd_word <= r_buf[r_rd_idx[c_ADDR_W-1:0]];
    end

    always_comb begin
        case (r_rd_plane)
            2'd0:    w_rd_byte = r_rd_word[23:16];
            2'd1:    w_rd_byte = r_rd_word[15:8];
            default: w_rd_byte = r_rd_word[7:0];
        endcase
    end

    // ---------------- indices and read stage ----------------
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_rd_done   <= 1'b0;
            r_pix_ready <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_plane  <= 2'd0;
            r_rd_start  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            // Ready follows the state we are heading into, so it drops on
            // the edge that takes the last pixel and rises as LOAD resumes.
            r_pix_ready <= (w_state_nxt == c_LOAD);
            if (w_accept) r_wr_idx <= w_last_wr ? '0 : r_wr_idx + 1'b1;
            if (w_issue)  r_rd_idx <= w_idx_wrap ? '0 : r_rd_idx + 1'b1;
            if (w_last_beat)
                r_rd_done <= 1'b0;
            else if (w_issue && (r_state == c_SEND_B) && w_idx_wrap)
                r_rd_done <= 1'b1;
            if (w_rd_adv) begin
                r_rd_vld   <= w_issue;
                r_rd_plane <= r_state - 2'd1;
                r_rd_start <= (r_state == c_SEND_R) && (r_rd_idx == '0);
                r_rd_last  <= (r_state == c_SEND_B) && w_idx_wrap;
            end
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_rgb_out     <= 8'd0;
            r_plane_sel   <= 2'd0;
            r_frame_start <= 1'b0;
            r_out_last    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            if (w_out_load) begin
                r_out_valid   <= r_rd_vld;
                r_frame_start <= r_rd_vld && r_rd_start;
                if (r_rd_vld) begin
                    r_rgb_out   <= w_rd_byte;
                    r_plane_sel <= r_rd_plane;
                    r_out_last  <= r_rd_last;
                end
            end
            r_frame_done <= w_last_beat;
            if (w_last_beat) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign pix_ready   = r_pix_ready;
    assign rgb_out     = r_rgb_out;
    assign out_valid   = r_out_valid;
    assign plane_sel   = r_plane_sel;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
